// File: rtl/threads_mask_pkg.sv
`default_nettype none
// ============================================================================
// Module   : threads_mask_pkg
// Brief    : Canonical threads_mask codes, geometry and sequencer state type.
// Revision : 1.0
// ============================================================================
package threads_mask_pkg;

    localparam int THREADS = 8;
    localparam int PAIRS   = 4;

    localparam logic [3:0] C_CODE_ALL  = 4'b0000;
    localparam logic [3:0] C_CODE_LOW  = 4'b1000;
    localparam logic [3:0] C_CODE_HIGH = 4'b1010;
    localparam logic [3:0] C_CODE_P0   = 4'b1100;
    localparam logic [3:0] C_CODE_P1   = 4'b1101;
    localparam logic [3:0] C_CODE_P2   = 4'b1110;
    localparam logic [3:0] C_CODE_P3   = 4'b1111;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } seq_state_t;

    // A pair is pending when either of its two threads is pending.
    function automatic logic [PAIRS-1:0] pair_reduce(input logic [THREADS-1:0] i_threads);
        logic [PAIRS-1:0] w_pairs;
        for (int k = 0; k < PAIRS; k++) begin
            w_pairs[k] = i_threads[2*k] | i_threads[2*k+1];
        end
        return w_pairs;
    endfunction

endpackage
`default_nettype wire

// File: rtl/threads_mask_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : threads_mask_sequencer_if
// Brief    : Request and mask-issue handshake bundle of the sequencer.
// Revision : 1.0
// ============================================================================
interface threads_mask_sequencer_if;
    import threads_mask_pkg::*;

    logic                 flush;
    logic                 req_valid;
    logic                 req_ready;
    logic [THREADS-1:0]   req_threads;
    logic                 mask_valid;
    logic                 mask_ready;
    logic [3:0]           threads_mask;
    logic                 mask_last;
    logic                 done;
    logic [2:0]           issue_cnt;

    // master: the sequencer itself; slave: scheduler plus mask consumer.
    modport master (
        input  flush, req_valid, req_threads, mask_ready,
        output req_ready, mask_valid, threads_mask, mask_last, done, issue_cnt
    );

    modport slave (
        output flush, req_valid, req_threads, mask_ready,
        input  req_ready, mask_valid, threads_mask, mask_last, done, issue_cnt
    );
endinterface
`default_nettype wire

// File: rtl/threads_mask_select.sv
`default_nettype none
// ============================================================================
// Module   : threads_mask_select
// Brief    : Picks the next threads_mask code covering the pending pairs.
// Revision : 1.0
// ============================================================================
module threads_mask_select
    import threads_mask_pkg::*;
#(
    parameter bit ALLOW_QUAD = 1'b1
) (
    input  wire logic [PAIRS-1:0] i_pair_req,
    output logic      [3:0]       o_code,
    output logic      [PAIRS-1:0] o_covered,
    output logic                  o_last
);

    always_comb begin
        o_code    = C_CODE_ALL;
        o_covered = '0;
        if (&i_pair_req) begin
            o_code    = C_CODE_ALL;
            o_covered = 4'b1111;
        end else if (ALLOW_QUAD && i_pair_req[0] && i_pair_req[1]) begin
            o_code    = C_CODE_LOW;
            o_covered = 4'b0011;
        end else if (ALLOW_QUAD && i_pair_req[2] && i_pair_req[3]) begin
            o_code    = C_CODE_HIGH;
            o_covered = 4'b1100;
        end else if (i_pair_req[0]) begin
            o_code    = C_CODE_P0;
            o_covered = 4'b0001;
        end else if (i_pair_req[1]) begin
            o_code    = C_CODE_P1;
            o_covered = 4'b0010;
        end else if (i_pair_req[2]) begin
            o_code    = C_CODE_P2;
            o_covered = 4'b0100;
        end else if (i_pair_req[3]) begin
            o_code    = C_CODE_P3;
            o_covered = 4'b1000;
        end
    end

    assign o_last = ((i_pair_req & ~o_covered) == '0);

endmodule
`default_nettype wire

// File: rtl/threads_mask_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : threads_mask_sequencer
// Brief    : Issues the threads_mask codes covering an 8-thread pending set.
// Revision : 1.0
// ============================================================================
module threads_mask_sequencer
    import threads_mask_pkg::*;
#(
    parameter bit ALLOW_QUAD = 1'b1
) (
    input  wire logic                clk,
    input  wire logic                reset_n,
    threads_mask_sequencer_if.master bus
);

    seq_state_t          r_state;
    logic [PAIRS-1:0]    r_pair_req;
    logic [3:0]          r_mask;
    logic                r_last;
    logic                r_done;
    logic [2:0]          r_cnt;

    seq_state_t          w_state_nxt;
    logic [PAIRS-1:0]    w_pair_nxt;
    logic [3:0]          w_mask_nxt;
    logic                w_last_nxt;
    logic                w_done_nxt;
    logic [2:0]          w_cnt_nxt;

    logic [PAIRS-1:0]    w_new_pairs;
    logic [PAIRS-1:0]    w_sel_pairs;
    logic [3:0]          w_sel_code;
    logic [PAIRS-1:0]    w_sel_covered;
    logic                w_sel_last;

    // r_pair_req holds the pairs still owed after the code currently presented.
    assign w_new_pairs = pair_reduce(bus.req_threads);
    assign w_sel_pairs = (r_state == ST_IDLE) ? w_new_pairs : r_pair_req;

    threads_mask_select #(
        .ALLOW_QUAD (ALLOW_QUAD)
    ) u_select (
        .i_pair_req (w_sel_pairs),
        .o_code     (w_sel_code),
        .o_covered  (w_sel_covered),
        .o_last     (w_sel_last)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pair_nxt  = r_pair_req;
        w_mask_nxt  = r_mask;
        w_last_nxt  = r_last;
        w_done_nxt  = 1'b0;
        w_cnt_nxt   = r_cnt;
        if (bus.flush) begin
            w_state_nxt = ST_IDLE;
            w_pair_nxt  = '0;
            w_last_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        w_cnt_nxt = 3'd0;
                        if (w_new_pairs != '0) begin
                            w_state_nxt = ST_ISSUE;
                            w_mask_nxt  = w_sel_code;
                            w_last_nxt  = w_sel_last;
                            w_pair_nxt  = w_new_pairs & ~w_sel_covered;
                        end else begin
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (bus.mask_ready) begin
                        w_cnt_nxt = (r_cnt == 3'd7) ? r_cnt : r_cnt + 3'd1;
                        if (r_last) begin
                            w_state_nxt = ST_IDLE;
                            w_last_nxt  = 1'b0;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_mask_nxt  = w_sel_code;
                            w_last_nxt  = w_sel_last;
                            w_pair_nxt  = r_pair_req & ~w_sel_covered;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_pair_req <= '0;
            r_mask     <= C_CODE_ALL;
            r_last     <= 1'b0;
            r_done     <= 1'b0;
            r_cnt      <= 3'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_pair_req <= w_pair_nxt;
            r_mask     <= w_mask_nxt;
            r_last     <= w_last_nxt;
            r_done     <= w_done_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    assign bus.req_ready    = (r_state == ST_IDLE) && reset_n;
    assign bus.mask_valid   = (r_state == ST_ISSUE);
    assign bus.threads_mask = r_mask;
    assign bus.mask_last    = r_last;
    assign bus.done         = r_done;
    assign bus.issue_cnt    = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_threads_mask_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_threads_mask_sequencer
// Brief    : Directed self-checking bench, quad-enabled and pair-only instances.
// Revision : 1.0
// ============================================================================
module tb_threads_mask_sequencer;

    logic       clk;
    logic       reset_n;
    logic       flush;
    logic       req_valid;
    logic [7:0] req_threads;
    logic       mask_ready;

    int checks;
    int failures;

    threads_mask_sequencer_if if_q ();
    threads_mask_sequencer_if if_n ();

    assign if_q.flush       = flush;
    assign if_q.req_valid   = req_valid;
    assign if_q.req_threads = req_threads;
    assign if_q.mask_ready  = mask_ready;
    assign if_n.flush       = flush;
    assign if_n.req_valid   = req_valid;
    assign if_n.req_threads = req_threads;
    assign if_n.mask_ready  = mask_ready;

    threads_mask_sequencer #(.ALLOW_QUAD(1'b1)) u_dut_q (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if_q.master)
    );

    threads_mask_sequencer #(.ALLOW_QUAD(1'b0)) u_dut_n (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if_n.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sync_idle();
        req_valid  = 1'b0;
        mask_ready = 1'b0;
        flush      = 1'b1;
        tick();
        flush      = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(); tick();
        checks += 6;
        if (if_q.mask_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", if_q.mask_valid); end
        if (if_q.threads_mask !== 4'b0000) begin failures++; $display("FAIL rst_mask got=%b exp=0000", if_q.threads_mask); end
        if (if_q.mask_last !== 1'b0) begin failures++; $display("FAIL rst_last got=%b exp=0", if_q.mask_last); end
        if (if_q.done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", if_q.done); end
        if (if_q.issue_cnt !== 3'd0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", if_q.issue_cnt); end
        if (if_q.req_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", if_q.req_ready); end
        reset_n = 1'b1;
        tick();
        checks++;
        if (if_q.req_ready !== 1'b1) begin failures++; $display("FAIL rel_ready got=%b exp=1", if_q.req_ready); end
    endtask

    task automatic test_full();
        req_valid = 1'b1; req_threads = 8'hFF; mask_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        checks += 4;
        if (if_q.mask_valid !== 1'b1) begin failures++; $display("FAIL full_valid got=%b exp=1", if_q.mask_valid); end
        if (if_q.threads_mask !== 4'b0000) begin failures++; $display("FAIL full_mask got=%b exp=0000", if_q.threads_mask); end
        if (if_q.mask_last !== 1'b1) begin failures++; $display("FAIL full_last got=%b exp=1", if_q.mask_last); end
        if (if_q.req_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", if_q.req_ready); end
        tick();
        checks += 4;
        if (if_q.mask_valid !== 1'b0) begin failures++; $display("FAIL full_end_valid got=%b exp=0", if_q.mask_valid); end
        if (if_q.done !== 1'b1) begin failures++; $display("FAIL full_done got=%b exp=1", if_q.done); end
        if (if_q.issue_cnt !== 3'd1) begin failures++; $display("FAIL full_cnt got=%0d exp=1", if_q.issue_cnt); end
        if (if_q.req_ready !== 1'b1) begin failures++; $display("FAIL full_ready2 got=%b exp=1", if_q.req_ready); end
        tick();
        checks++;
        if (if_q.done !== 1'b0) begin failures++; $display("FAIL full_done_pulse got=%b exp=0", if_q.done); end
        sync_idle();
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1; req_threads = 8'h3C; mask_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        checks += 2;
        if (if_q.threads_mask !== 4'b1101) begin failures++; $display("FAIL b2b_m0 got=%b exp=1101", if_q.threads_mask); end
        if (if_q.mask_last !== 1'b0) begin failures++; $display("FAIL b2b_l0 got=%b exp=0", if_q.mask_last); end
        tick();
        checks += 3;
        if (if_q.mask_valid !== 1'b1) begin failures++; $display("FAIL b2b_v1 got=%b exp=1", if_q.mask_valid); end
        if (if_q.threads_mask !== 4'b1110) begin failures++; $display("FAIL b2b_m1 got=%b exp=1110", if_q.threads_mask); end
        if (if_q.mask_last !== 1'b1) begin failures++; $display("FAIL b2b_l1 got=%b exp=1", if_q.mask_last); end
        tick();
        checks += 2;
        if (if_q.done !== 1'b1) begin failures++; $display("FAIL b2b_done got=%b exp=1", if_q.done); end
        if (if_q.issue_cnt !== 3'd2) begin failures++; $display("FAIL b2b_cnt got=%0d exp=2", if_q.issue_cnt); end
        sync_idle();

        // Pairs 0..2: quad instance takes LOW+P2, pair-only takes P0,P1,P2.
        req_valid = 1'b1; req_threads = 8'h1F; mask_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        checks += 2;
        if (if_q.threads_mask !== 4'b1000) begin failures++; $display("FAIL quad_m0 got=%b exp=1000", if_q.threads_mask); end
        if (if_n.threads_mask !== 4'b1100) begin failures++; $display("FAIL pair_m0 got=%b exp=1100", if_n.threads_mask); end
        tick();
        checks += 4;
        if (if_q.threads_mask !== 4'b1110) begin failures++; $display("FAIL quad_m1 got=%b exp=1110", if_q.threads_mask); end
        if (if_q.mask_last !== 1'b1) begin failures++; $display("FAIL quad_l1 got=%b exp=1", if_q.mask_last); end
        if (if_n.threads_mask !== 4'b1101) begin failures++; $display("FAIL pair_m1 got=%b exp=1101", if_n.threads_mask); end
        if (if_n.mask_last !== 1'b0) begin failures++; $display("FAIL pair_l1 got=%b exp=0", if_n.mask_last); end
        tick();
        checks += 4;
        if (if_q.done !== 1'b1) begin failures++; $display("FAIL quad_done got=%b exp=1", if_q.done); end
        if (if_q.issue_cnt !== 3'd2) begin failures++; $display("FAIL quad_cnt got=%0d exp=2", if_q.issue_cnt); end
        if (if_n.threads_mask !== 4'b1110) begin failures++; $display("FAIL pair_m2 got=%b exp=1110", if_n.threads_mask); end
        if (if_n.mask_last !== 1'b1) begin failures++; $display("FAIL pair_l2 got=%b exp=1", if_n.mask_last); end
        tick();
        checks += 2;
        if (if_n.done !== 1'b1) begin failures++; $display("FAIL pair_done got=%b exp=1", if_n.done); end
        if (if_n.issue_cnt !== 3'd3) begin failures++; $display("FAIL pair_cnt got=%0d exp=3", if_n.issue_cnt); end
        sync_idle();
    endtask

    task automatic test_backpressure();
        req_valid = 1'b1; req_threads = 8'h81; mask_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks += 3;
            if (if_q.mask_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, if_q.mask_valid); end
            if (if_q.threads_mask !== 4'b1100) begin failures++; $display("FAIL bp_mask[%0d] got=%b exp=1100", i, if_q.threads_mask); end
            if (if_q.done !== 1'b0) begin failures++; $display("FAIL bp_done[%0d] got=%b exp=0", i, if_q.done); end
            tick();
        end
        mask_ready = 1'b1;
        tick();
        checks += 2;
        if (if_q.threads_mask !== 4'b1111) begin failures++; $display("FAIL bp_m1 got=%b exp=1111", if_q.threads_mask); end
        if (if_q.mask_last !== 1'b1) begin failures++; $display("FAIL bp_l1 got=%b exp=1", if_q.mask_last); end
        tick();
        checks += 2;
        if (if_q.done !== 1'b1) begin failures++; $display("FAIL bp_done_end got=%b exp=1", if_q.done); end
        if (if_q.issue_cnt !== 3'd2) begin failures++; $display("FAIL bp_cnt got=%0d exp=2", if_q.issue_cnt); end
        sync_idle();
    endtask

    task automatic test_empty();
        req_valid = 1'b1; req_threads = 8'h00; mask_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        checks += 4;
        if (if_q.mask_valid !== 1'b0) begin failures++; $display("FAIL empty_valid got=%b exp=0", if_q.mask_valid); end
        if (if_q.done !== 1'b1) begin failures++; $display("FAIL empty_done got=%b exp=1", if_q.done); end
        if (if_q.req_ready !== 1'b1) begin failures++; $display("FAIL empty_ready got=%b exp=1", if_q.req_ready); end
        if (if_q.issue_cnt !== 3'd0) begin failures++; $display("FAIL empty_cnt got=%0d exp=0", if_q.issue_cnt); end
        tick();
        checks++;
        if (if_q.done !== 1'b0) begin failures++; $display("FAIL empty_done_pulse got=%b exp=0", if_q.done); end
        sync_idle();
    endtask

    task automatic test_flush();
        req_valid = 1'b1; req_threads = 8'h15; mask_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        checks++;
        if (if_n.threads_mask !== 4'b1100) begin failures++; $display("FAIL fl_m0 got=%b exp=1100", if_n.threads_mask); end
        tick();
        checks += 2;
        if (if_n.threads_mask !== 4'b1101) begin failures++; $display("FAIL fl_m1 got=%b exp=1101", if_n.threads_mask); end
        if (if_q.mask_last !== 1'b1) begin failures++; $display("FAIL fl_qlast got=%b exp=1", if_q.mask_last); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks += 5;
        if (if_n.mask_valid !== 1'b0) begin failures++; $display("FAIL fl_valid got=%b exp=0", if_n.mask_valid); end
        if (if_n.done !== 1'b0) begin failures++; $display("FAIL fl_done got=%b exp=0", if_n.done); end
        if (if_n.req_ready !== 1'b1) begin failures++; $display("FAIL fl_ready got=%b exp=1", if_n.req_ready); end
        if (if_n.issue_cnt !== 3'd1) begin failures++; $display("FAIL fl_cnt got=%0d exp=1", if_n.issue_cnt); end
        if (if_q.done !== 1'b0) begin failures++; $display("FAIL fl_qdone got=%b exp=0", if_q.done); end
        tick();
        checks += 2;
        if (if_n.mask_valid !== 1'b0) begin failures++; $display("FAIL fl_valid2 got=%b exp=0", if_n.mask_valid); end
        if (if_n.done !== 1'b0) begin failures++; $display("FAIL fl_done2 got=%b exp=0", if_n.done); end
        sync_idle();
    endtask

    task automatic test_reset_mid_issue();
        req_valid = 1'b1; req_threads = 8'h3C; mask_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        checks++;
        if (if_q.mask_valid !== 1'b1) begin failures++; $display("FAIL rm_pre_valid got=%b exp=1", if_q.mask_valid); end
        reset_n = 1'b0;
        tick();
        checks += 6;
        if (if_q.mask_valid !== 1'b0) begin failures++; $display("FAIL rm_valid got=%b exp=0", if_q.mask_valid); end
        if (if_q.threads_mask !== 4'b0000) begin failures++; $display("FAIL rm_mask got=%b exp=0000", if_q.threads_mask); end
        if (if_q.mask_last !== 1'b0) begin failures++; $display("FAIL rm_last got=%b exp=0", if_q.mask_last); end
        if (if_q.done !== 1'b0) begin failures++; $display("FAIL rm_done got=%b exp=0", if_q.done); end
        if (if_q.issue_cnt !== 3'd0) begin failures++; $display("FAIL rm_cnt got=%0d exp=0", if_q.issue_cnt); end
        if (if_q.req_ready !== 1'b0) begin failures++; $display("FAIL rm_ready got=%b exp=0", if_q.req_ready); end
        reset_n = 1'b1;
        req_valid = 1'b1; req_threads = 8'hF0; mask_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        checks += 4;
        if (if_q.threads_mask !== 4'b1010) begin failures++; $display("FAIL rm_high got=%b exp=1010", if_q.threads_mask); end
        if (if_q.mask_last !== 1'b1) begin failures++; $display("FAIL rm_high_last got=%b exp=1", if_q.mask_last); end
        if (if_n.threads_mask !== 4'b1110) begin failures++; $display("FAIL rm_p2 got=%b exp=1110", if_n.threads_mask); end
        if (if_n.mask_last !== 1'b0) begin failures++; $display("FAIL rm_p2_last got=%b exp=0", if_n.mask_last); end
        tick();
        checks += 3;
        if (if_q.done !== 1'b1) begin failures++; $display("FAIL rm_done_end got=%b exp=1", if_q.done); end
        if (if_q.issue_cnt !== 3'd1) begin failures++; $display("FAIL rm_cnt_end got=%0d exp=1", if_q.issue_cnt); end
        if (if_n.threads_mask !== 4'b1111) begin failures++; $display("FAIL rm_p3 got=%b exp=1111", if_n.threads_mask); end
        sync_idle();
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset_n     = 1'b0;
        flush       = 1'b0;
        req_valid   = 1'b0;
        req_threads = 8'h00;
        mask_ready  = 1'b0;
        test_reset();
        test_full();
        test_back_to_back();
        test_backpressure();
        test_empty();
        test_flush();
        test_reset_mid_issue();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
